mono_fb_arbiter: RTL and testbench
==================================

Name: mono_fb_arbiter

Overview:
- Sits between the dither stage (16-pixel mono words in the 16 MHz domain) and the Mac CRT timing generator.
- Owns the single port of the 512x512x1 SPRAM framebuffer. Scanout reads have absolute priority; dither writes are queued in a small FIFO and drained only in slots where no read is due.
- Serialises each read word into the one-bit video stream consumed by the CRT generator.

Parameters:
- FIFO_DEPTH, 4: write FIFO entries; power of two, minimum 2.
- ADDR_W, 14: SPRAM word address width.
- DATA_W, 16: pixels per word.

Ports:
- clk  in  1  16 MHz pixel clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_valid  in  1  one-cycle pulse: the dither word is valid. There is no backpressure.
- wr_xaddr  in  12  dither x address; bits [3:0] are always 0.
- wr_yaddr  in  12  dither y address.
- wr_data  in  16  pixel word, MSB is the leftmost pixel.
- frame_start  in  1  one-cycle pulse at dither vsync; clears the overflow flag.
- scan_xaddr  in  10  CRT pixel request x.
- scan_yaddr  in  9  CRT pixel request y.
- scan_active  in  1  the CRT is inside the active window; reads are allowed.
- ram_addr  out  14  SPRAM address.
- ram_wen  out  1  SPRAM write enable.
- ram_wr_data  out  16  SPRAM write data.
- ram_rd_data  in  16  SPRAM read data; valid the cycle after the address.
- video_bit  out  1  current pixel; 1 = black.
- overflow  out  1  sticky flag: a write was dropped.
- fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (reset=0, async): FIFO empty, shifter=0, read_pending=0, overflow=0. Outputs held at ram_wen=0, ram_addr=0, ram_wr_data=0, video_bit=0.
- Write address mapping: {wr_yaddr[8:0], wr_xaddr[8:4]}. Read address mapping: {scan_yaddr[8:0], scan_xaddr[8:4]}.
- Read slot:
  - Occurs when scan_active=1 and scan_xaddr[3:0]==0.
  - ram_addr carries the read address combinationally, ram_wen=0.
  - read_pending is set for the next cycle.
- Write slot (every non-read cycle):
  - If the FIFO is non-empty: pop the head, drive ram_addr=head addr, ram_wr_data=head data, ram_wen=1.
  - Otherwise ram_wen=0 and ram_addr holds its last value.
- Push:
  - wr_valid pushes {addr, data} at the clock edge. The entry is poppable from the next cycle, so the minimum wr_valid-to-ram_wen latency is 1 cycle.
  - Full and no pop in the same cycle: the new word is dropped, the FIFO is unchanged, and overflow is set.
  - Full with a pop in the same cycle: the push is accepted and the level is unchanged.
  - Empty with a push: no same-cycle bypass.
- overflow:
  - Cleared by frame_start.
  - If frame_start and a drop occur in the same cycle, the set wins.
- Scanout shifter:
  - Cycle after a read (read_pending=1): video_bit=ram_rd_data[15] combinationally; shifter <= {ram_rd_data[14:0],0}.
  - Other cycles: video_bit=shifter[15]; shifter <= shifter<<1.
  - Outside the active window, reads stop and the shifter drains to 0, so video_bit reads 0 (white).
- Throughput: at most 1 read per 16 cycles during active video, leaving 15 write slots per 16 cycles. The dither produces at most 1 word per 16 of its cycles, so the FIFO cannot overflow in steady state.
- Address ordering: multiple FIFO entries with the same address drain in push order, so the last write wins.
- No combinational path from wr_* to ram_*.

Optional Feature:
- Macro: MONO_FB_PATTERN_EN.
- When defined:
  - Adds input pattern_sel (1 bit).
  - While pattern_sel=1, the read word is replaced by a checkerboard: 16'hAAAA on even scan_yaddr, 16'h5555 on odd, using the scan_yaddr registered at the read slot.
  - SPRAM reads still occur and FIFO draining is unaffected.
- When undefined: no port, no logic, and the behaviour is exactly as above.

Decomposition:
- Package mono_fb_pkg holds:
  - Constants: FB_WORD_W=16, FB_ADDR_W=14, FB_XWORDS=32, FB_LINES=512.
  - A function fb_word_addr(y, x) that returns {y[8:0], x[8:4]}.
  - The FIFO entry typedef {addr[13:0], data[15:0]}.
- Sub-module mono_fb_wfifo: synchronous FIFO with push/pop/full/empty/level. Same clk and async active-low reset; the drop-on-full policy lives in the parent.

Test Plan:
- Reset mid-operation: 3 entries queued, reset=0 for 1 cycle, then release → fifo_level=0, ram_wen=0, video_bit=0, overflow=0, and no stale write is issued.
- Read priority: wr_valid at the same cycle scan_xaddr=0x10, scan_active=1, yaddr=5 → ram_addr=0x0A1 with ram_wen=0 in that cycle. The write (addr from wr_y=3, wr_x=0x20 → 0x062) issues on the next non-read cycle.
- Serialisation: ram_rd_data=16'h8001 after a read → video_bit sequence 1,0×14,1 over the 16 cycles; then 0 outside the window.
- Overflow: 5 back-to-back wr_valid with scan forcing back-to-back read slots (no drain) → first 4 accepted, 5th dropped, overflow=1, level=4. frame_start → overflow=0.
- Full with simultaneous push and pop: level=4 and a write slot, push same cycle → level stays 4, overflow stays 0. Pushed words appear on ram_wr_data in push order.
- Same-address ordering: two writes to addr 0x100 with data 0x1234 then 0xFFFF → SPRAM final content 0xFFFF. A subsequent read returns 0xFFFF.

Source files
------------

// File: rtl/mono_fb_arbiter_pkg.sv
// mono_fb_pkg: shared constants, the framebuffer word-address helper and
// the write FIFO entry type for the mono framebuffer arbiter.
package mono_fb_pkg;

  localparam int FB_WORD_W = 16;
  localparam int FB_ADDR_W = 14;
  localparam int FB_XWORDS = 32;
  localparam int FB_LINES  = 512;

  // One framebuffer line is FB_XWORDS words; the line index forms the high bits
  function automatic logic [FB_ADDR_W-1:0] fb_word_addr(input logic [8:0] y,
                                                        input logic [8:4] x);
    return {y, x};
  endfunction

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_WORD_W-1:0] data;
  } fb_entry_t;

endpackage

// File: rtl/mono_fb_arbiter_if.sv
// mono_fb_arbiter_if: single-port SPRAM bus between the arbiter (master)
// and the framebuffer RAM (slave). Read data is valid the cycle after the
// address is presented.
interface mono_fb_arbiter_if;
  import mono_fb_pkg::*;

  logic [FB_ADDR_W-1:0] ram_addr;
  logic                 ram_wen;
  logic [FB_WORD_W-1:0] ram_wr_data;
  logic [FB_WORD_W-1:0] ram_rd_data;

  modport master (output ram_addr, output ram_wen, output ram_wr_data,
                  input  ram_rd_data);
  modport slave  (input  ram_addr, input  ram_wen, input  ram_wr_data,
                  output ram_rd_data);
endinterface

// File: rtl/mono_fb_arbiter_wfifo.sv
// mono_fb_wfifo: small synchronous FIFO holding queued dither writes.
// The head entry is visible combinationally; the parent decides whether a
// push is allowed when full (drop policy lives there).
module mono_fb_wfifo
  import mono_fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fb_entry_t              din,
  output fb_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);

  fb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Storage write; a push while full only happens together with a pop,
  // and the head has already been read out combinationally by then
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mono_fb_arbiter.sv
// mono_fb_arbiter: owns the framebuffer SPRAM port. Scanout reads win every
// slot they need; dither writes queue in mono_fb_wfifo and drain in the
// remaining slots. Each read word is shifted out MSB first as video_bit.
// Optional build macro MONO_FB_PATTERN_EN adds a checkerboard test pattern.
module mono_fb_arbiter
  import mono_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  input  logic [11:0]                 wr_xaddr,
  input  logic [11:0]                 wr_yaddr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        frame_start,
  input  logic [9:0]                  scan_xaddr,
  input  logic [8:0]                  scan_yaddr,
  input  logic                        scan_active,
`ifdef MONO_FB_PATTERN_EN
  input  logic                        pattern_sel,
`endif
  mono_fb_arbiter_if.master           ram,
  output logic                        video_bit,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  logic              read_slot;
  logic              pop;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  fb_entry_t         head;
  fb_entry_t         wr_entry;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic              read_pending;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] rd_word;
  logic              unused_bits;

  assign read_slot = scan_active && (scan_xaddr[3:0] == 4'd0);
  assign pop       = !read_slot && !fifo_empty;
  assign push      = wr_valid && (!fifo_full || pop);
  assign drop      = wr_valid && fifo_full && !pop;
  assign rd_addr   = fb_word_addr(scan_yaddr, scan_xaddr[8:4]);
  assign wr_entry  = '{addr: fb_word_addr(wr_yaddr[8:0], wr_xaddr[8:4]),
                       data: wr_data};

  assign unused_bits = ^{wr_xaddr[11:9], wr_xaddr[3:0], wr_yaddr[11:9],
                         scan_xaddr[9]};

  mono_fb_wfifo #(.DEPTH(FIFO_DEPTH)) u_wfifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef MONO_FB_PATTERN_EN
  logic pat_odd_q;

  // Remember the parity of the line being read so the pattern matches it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         pat_odd_q <= 1'b0;
    else if (read_slot) pat_odd_q <= scan_yaddr[0];
  end

  assign rd_word = pattern_sel ? (pat_odd_q ? 16'h5555 : 16'hAAAA)
                               : ram.ram_rd_data;
`else
  assign rd_word = ram.ram_rd_data;
`endif

  // Address mux: read slot first, then a draining write, otherwise hold
  always_comb begin
    addr_nxt = addr_q;
    if (read_slot)  addr_nxt = rd_addr;
    else if (pop)   addr_nxt = head.addr;
  end

  // Drive the RAM bus and video output; everything is forced idle in reset
  always_comb begin
    ram.ram_addr    = '0;
    ram.ram_wen     = 1'b0;
    ram.ram_wr_data = '0;
    video_bit       = 1'b0;
    if (reset) begin
      ram.ram_addr    = addr_nxt;
      ram.ram_wen     = pop;
      ram.ram_wr_data = pop ? head.data : '0;
      video_bit       = read_pending ? rd_word[DATA_W-1] : shifter[DATA_W-1];
    end
  end

  // Address holding register, read tracking, pixel shifter and sticky overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q       <= '0;
      read_pending <= 1'b0;
      shifter      <= '0;
      overflow     <= 1'b0;
    end else begin
      addr_q       <= addr_nxt;
      read_pending <= read_slot;
      shifter      <= read_pending ? {rd_word[DATA_W-2:0], 1'b0}
                                   : {shifter[DATA_W-2:0], 1'b0};
      if (drop)             overflow <= 1'b1;
      else if (frame_start) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mono_fb_arbiter.sv
// tb_mono_fb_arbiter: directed vectors with hand-computed expectations for
// the framebuffer arbiter, including a behavioural SPRAM model.
module tb_mono_fb_arbiter;
  import mono_fb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_valid = 1'b0;
  logic [11:0] wr_xaddr = '0;
  logic [11:0] wr_yaddr = '0;
  logic [15:0] wr_data = '0;
  logic        frame_start = 1'b0;
  logic [9:0]  scan_xaddr = '0;
  logic [8:0]  scan_yaddr = '0;
  logic        scan_active = 1'b0;
`ifdef MONO_FB_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif
  logic        video_bit;
  logic        overflow;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad = 0;

  logic        pre_en = 1'b0;
  logic [13:0] pre_addr = '0;
  logic [15:0] pre_data = '0;
  logic [15:0] mem [16384] = '{default: 16'h0000};

  logic [13:0] drain_addr [4] = '{14'h141, 14'h142, 14'h143, 14'h160};
  logic [15:0] drain_data [4] = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};
  logic [15:0] ovf_data   [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
  logic [15:0] pat;
  logic        exp_bit;

  mono_fb_arbiter_if ram_if ();

  mono_fb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_xaddr    (wr_xaddr),
    .wr_yaddr    (wr_yaddr),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .scan_xaddr  (scan_xaddr),
    .scan_yaddr  (scan_yaddr),
    .scan_active (scan_active),
`ifdef MONO_FB_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .ram         (ram_if),
    .video_bit   (video_bit),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  // SPRAM model: registered read, write on wen, bench preload when idle
  always @(posedge clk) begin
    if (ram_if.ram_wen) mem[ram_if.ram_addr] <= ram_if.ram_wr_data;
    else if (pre_en)    mem[pre_addr] <= pre_data;
    ram_if.ram_rd_data <= mem[ram_if.ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, settle, return for checks
  task automatic applyStimulus(input logic wv, input logic [11:0] wx,
                               input logic [11:0] wy, input logic [15:0] wd,
                               input logic fs, input logic sa,
                               input logic [9:0] sx, input logic [8:0] sy);
    @(negedge clk);
    pre_en      = 1'b0;
    wr_valid    = wv;
    wr_xaddr    = wx;
    wr_yaddr    = wy;
    wr_data     = wd;
    frame_start = fs;
    scan_active = sa;
    scan_xaddr  = sx;
    scan_yaddr  = sy;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 10'h001, '0);
  endtask

  initial begin
    // Reset state, with a read slot presented while reset is held
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h010, 9'd5);
    checkOutput("rst_addr", 32'(ram_if.ram_addr), 32'h0);
    checkOutput("rst_wen", 32'(ram_if.ram_wen), 32'h0);
    checkOutput("rst_video", 32'(video_bit), 32'h0);
    checkOutput("rst_ovf", 32'(overflow), 32'h0);
    checkOutput("rst_level", 32'(fifo_level), 32'h0);
    reset = 1'b1;
    idleCycle();
    checkOutput("post_rst_wen", 32'(ram_if.ram_wen), 32'h0);

    // Read priority over a same-cycle write
    applyStimulus(1'b1, 12'h020, 12'h003, 16'hBEEF, 1'b0, 1'b1, 10'h010, 9'd5);
    checkOutput("prio_rd_addr", 32'(ram_if.ram_addr), 32'h0A1);
    checkOutput("prio_rd_wen", 32'(ram_if.ram_wen), 32'h0);
    checkOutput("prio_level0", 32'(fifo_level), 32'h0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h011, 9'd5);
    checkOutput("prio_wr_wen", 32'(ram_if.ram_wen), 32'h1);
    checkOutput("prio_wr_addr", 32'(ram_if.ram_addr), 32'h062);
    checkOutput("prio_wr_data", 32'(ram_if.ram_wr_data), 32'hBEEF);
    checkOutput("prio_level1", 32'(fifo_level), 32'h1);
    idleCycle();
    checkOutput("prio_idle_wen", 32'(ram_if.ram_wen), 32'h0);
    checkOutput("prio_hold_addr", 32'(ram_if.ram_addr), 32'h062);
    checkOutput("prio_level_end", 32'(fifo_level), 32'h0);

    // Serialisation of 16'h8001 read from address 0x123
    idleCycle();
    pre_addr = 14'h123;
    pre_data = 16'h8001;
    pre_en   = 1'b1;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h030, 9'd9);
    checkOutput("ser_rd_addr", 32'(ram_if.ram_addr), 32'h123);
    pat = 16'h8001;
    for (int k = 0; k < 18; k++) begin
      applyStimulus(1'b0, '0, '0, '0, 1'b0, (k < 15), 10'(10'h031 + k), 9'd9);
      if (k < 16) exp_bit = pat[15-k];
      else        exp_bit = 1'b0;
      checkOutput($sformatf("ser_bit%0d", k), 32'(video_bit), 32'(exp_bit));
    end

    // Overflow: back-to-back read slots, five pushes, the fifth is dropped
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 12'(i * 16), 12'd10, ovf_data[i], 1'b0, 1'b1, 10'h000, 9'd0);
      checkOutput($sformatf("ovf_level%0d", i), 32'(fifo_level), 32'((i < 4) ? i : 4));
      checkOutput($sformatf("ovf_flag%0d", i), 32'(overflow), 32'h0);
      checkOutput($sformatf("ovf_wen%0d", i), 32'(ram_if.ram_wen), 32'h0);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 10'h000, 9'd0);
    checkOutput("ovf_set", 32'(overflow), 32'h1);
    checkOutput("ovf_level_full", 32'(fifo_level), 32'h4);
    applyStimulus(1'b1, 12'h0F0, 12'd10, 16'h7777, 1'b1, 1'b1, 10'h000, 9'd0);
    checkOutput("ovf_cleared", 32'(overflow), 32'h0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h000, 9'd0);
    checkOutput("ovf_set_wins", 32'(overflow), 32'h1);
    checkOutput("ovf_level_keep", 32'(fifo_level), 32'h4);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 10'h000, 9'd0);
    checkOutput("ovf_before_clr", 32'(overflow), 32'h1);

    // Full FIFO with push and pop in the same write slot
    applyStimulus(1'b1, 12'h000, 12'd11, 16'h6666, 1'b0, 1'b0, 10'h001, 9'd0);
    checkOutput("fpp_ovf", 32'(overflow), 32'h0);
    checkOutput("fpp_level", 32'(fifo_level), 32'h4);
    checkOutput("fpp_wen", 32'(ram_if.ram_wen), 32'h1);
    checkOutput("fpp_addr", 32'(ram_if.ram_addr), 32'h140);
    checkOutput("fpp_data", 32'(ram_if.ram_wr_data), 32'h1111);
    for (int j = 0; j < 4; j++) begin
      idleCycle();
      checkOutput($sformatf("drain_level%0d", j), 32'(fifo_level), 32'(4 - j));
      checkOutput($sformatf("drain_wen%0d", j), 32'(ram_if.ram_wen), 32'h1);
      checkOutput($sformatf("drain_addr%0d", j), 32'(ram_if.ram_addr), 32'(drain_addr[j]));
      checkOutput($sformatf("drain_data%0d", j), 32'(ram_if.ram_wr_data), 32'(drain_data[j]));
      checkOutput($sformatf("drain_ovf%0d", j), 32'(overflow), 32'h0);
    end
    idleCycle();
    checkOutput("drain_done_wen", 32'(ram_if.ram_wen), 32'h0);
    checkOutput("drain_done_level", 32'(fifo_level), 32'h0);
    checkOutput("drain_hold_addr", 32'(ram_if.ram_addr), 32'h160);

    // Same-address ordering: last write wins, then read it back
    applyStimulus(1'b1, 12'h000, 12'd8, 16'h1234, 1'b0, 1'b0, 10'h001, 9'd0);
    checkOutput("same_no_bypass", 32'(ram_if.ram_wen), 32'h0);
    applyStimulus(1'b1, 12'h000, 12'd8, 16'hFFFF, 1'b0, 1'b0, 10'h001, 9'd0);
    checkOutput("same_first_addr", 32'(ram_if.ram_addr), 32'h100);
    checkOutput("same_first_data", 32'(ram_if.ram_wr_data), 32'h1234);
    idleCycle();
    checkOutput("same_second_wen", 32'(ram_if.ram_wen), 32'h1);
    checkOutput("same_second_data", 32'(ram_if.ram_wr_data), 32'hFFFF);
    idleCycle();
    checkOutput("same_mem", 32'(mem[14'h100]), 32'hFFFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h000, 9'd8);
    checkOutput("same_rd_addr", 32'(ram_if.ram_addr), 32'h100);
    for (int k = 0; k < 17; k++) begin
      idleCycle();
      checkOutput($sformatf("same_bit%0d", k), 32'(video_bit), (k < 16) ? 32'h1 : 32'h0);
    end

    // Reset in the middle of operation with a full FIFO and overflow set
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 12'(i * 16), 12'd12, 16'hA000 + 16'(i), 1'b0, 1'b1, 10'h000, 9'd8);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h000, 9'd8);
    checkOutput("mid_level", 32'(fifo_level), 32'h4);
    checkOutput("mid_ovf", 32'(overflow), 32'h1);
    checkOutput("mid_video", 32'(video_bit), 32'h1);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 10'h000, 9'd8);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_level", 32'(fifo_level), 32'h0);
    checkOutput("mid_rst_wen", 32'(ram_if.ram_wen), 32'h0);
    checkOutput("mid_rst_addr", 32'(ram_if.ram_addr), 32'h0);
    checkOutput("mid_rst_video", 32'(video_bit), 32'h0);
    checkOutput("mid_rst_ovf", 32'(overflow), 32'h0);
    idleCycle();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("mid_stale_wen%0d", k), 32'(ram_if.ram_wen), 32'h0);
      checkOutput($sformatf("mid_stale_level%0d", k), 32'(fifo_level), 32'h0);
      checkOutput($sformatf("mid_stale_video%0d", k), 32'(video_bit), 32'h0);
      idleCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
